// File: rtl/mult_ctrl_pkg.sv
// Shared types and defaults for the multiplier-sharing controller.
package mult_ctrl_pkg;

  typedef enum logic [2:0] {IDLE, CLR, LOAD, RUN, DONE} state_t;

  localparam int DEF_WIDTH    = 32;
  localparam int DEF_NREQ     = 4;
  localparam int DEF_MULT_LAT = 34;

  // Id width never collapses to zero, even for a degenerate single requester.
  function automatic int calc_idw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr.
module rr_arbiter
  import mult_ctrl_pkg::*;
#(
  parameter int  NREQ = DEF_NREQ,
  localparam int IDW  = calc_idw(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx
);

  logic           found;
  logic [IDW-1:0] sel;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    sel     = '0;
    for (int i = 0; i < NREQ; i++) begin
      sel = IDW'((int'(ptr) + i) % NREQ);
      if (!found && req[sel]) begin
        found    = 1'b1;
        gnt[sel] = 1'b1;
        gnt_idx  = sel;
      end
    end
  end

endmodule

// File: rtl/mult_share_ctrl.sv
// Shares one sequential multiplier core among NREQ requesters: arbitrate, clear the core,
// load operands, count a fixed latency, then hold the tagged product until it is taken.
module mult_share_ctrl
  import mult_ctrl_pkg::*;
#(
  parameter int  WIDTH    = DEF_WIDTH,
  parameter int  NREQ     = DEF_NREQ,
  parameter int  MULT_LAT = DEF_MULT_LAT,
  localparam int IDW      = calc_idw(NREQ),
  localparam int CNTW     = $clog2(MULT_LAT + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [2*WIDTH-1:0]    rsp_data,
  output logic                  busy,
  output logic                  mul_rst,
  output logic                  mul_en,
  output logic                  mul_load,
  output logic [WIDTH-1:0]      mul_a,
  output logic [WIDTH-1:0]      mul_b,
  input  logic [2*WIDTH-1:0]    mul_out
);

  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(MULT_LAT - 1);
  localparam logic [IDW-1:0]  ID_LAST  = IDW'(NREQ - 1);

  state_t             state;
  state_t             state_nxt;
  logic [IDW-1:0]     ptr;
  logic [IDW-1:0]     id;
  logic [IDW-1:0]     gnt_idx;
  logic [NREQ-1:0]    gnt;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;
  logic [CNTW-1:0]    cnt;
  logic [2*WIDTH-1:0] product;
  logic               grant;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req     (req_valid),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign grant = (state == IDLE) && (|req_valid);

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_a = req_a[i*WIDTH +: WIDTH];
        sel_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (grant) state_nxt = CLR;
      CLR:     state_nxt = LOAD;
      LOAD:    state_nxt = RUN;
      RUN:     if (cnt == CNT_LAST) state_nxt = DONE;
      DONE:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The grant is gated by reset so no requester sees an accept while the block is held.
  always_comb begin
    req_ready = '0;
    if (rst && grant) req_ready = gnt;
  end

  assign rsp_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign mul_rst   = (state == CLR) || !rst;
  assign mul_en    = (state == LOAD) || (state == RUN);
  assign mul_load  = (state == LOAD);
  assign mul_a     = op_a;
  assign mul_b     = op_b;
  assign rsp_id    = id;
  assign rsp_data  = product;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr     <= '0;
      id      <= '0;
      op_a    <= '0;
      op_b    <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      if (grant) begin
        ptr  <= (gnt_idx == ID_LAST) ? '0 : gnt_idx + IDW'(1);
        id   <= gnt_idx;
        op_a <= sel_a;
        op_b <= sel_b;
      end
      if (state == LOAD) begin
        cnt <= '0;
      end else if (state == RUN) begin
        cnt <= cnt + CNTW'(1);
        // The core has no done flag; the fixed latency is the only proof OUT is valid.
        if (cnt == CNT_LAST) product <= mul_out;
      end
    end
  end

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Self-checking bench for mult_share_ctrl: a latency-accurate core model drives mul_out,
// and a job-timeline reference model is compared against every output on every cycle.
module tb_mult_share_ctrl;

  localparam int W   = 32;
  localparam int N   = 4;
  localparam int LAT = 34;
  localparam int IDW = 2;
  localparam logic [2*W-1:0] JUNK = 64'hA5A5_5A5A_C3C3_3C3C;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_a;
  logic [N*W-1:0]   req_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [IDW-1:0]   rsp_id;
  logic [2*W-1:0]   rsp_data;
  logic             busy;
  logic             mul_rst;
  logic             mul_en;
  logic             mul_load;
  logic [W-1:0]     mul_a;
  logic [W-1:0]     mul_b;
  logic [2*W-1:0]   mul_out;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [N-1:0] valid_r;
  logic [W-1:0] a_r [N];
  logic [W-1:0] b_r [N];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign req_valid = valid_r;
  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = a_r[i];
      req_b[i*W +: W] = b_r[i];
    end
  end

  mult_share_ctrl #(.WIDTH(W), .NREQ(N), .MULT_LAT(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .mul_rst   (mul_rst),
    .mul_en    (mul_en),
    .mul_load  (mul_load),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_out   (mul_out)
  );

  function automatic logic [2*W-1:0] mulref(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [2*W-1:0] ea;
    logic signed [2*W-1:0] eb;
    ea = {{W{a[W-1]}}, a};
    eb = {{W{b[W-1]}}, b};
    return ea * eb;
  endfunction

  // Core model: OUT is the true product only LAT cycles after the load cycle, garbage otherwise.
  int             core_k = -1;
  logic [2*W-1:0] core_p = '0;
  always @(posedge clk) begin
    if (mul_rst) core_k <= -1;
    else if (mul_load) begin
      core_p <= mulref(mul_a, mul_b);
      core_k <= 0;
    end else if (mul_en && core_k >= 0) core_k <= core_k + 1;
  end
  assign mul_out = (core_k == LAT - 1) ? core_p : (core_p ^ JUNK);

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: m_t is the number of cycles since the job's grant, -1 when idle.
  int             m_t = -1;
  int             m_ptr = 0;
  int             m_id = 0;
  logic [W-1:0]   m_a, m_b;
  logic [2*W-1:0] m_prod;
  int             g;
  logic [N-1:0]   e_ready;
  logic [N-1:0]   seen_ready = '0;
  logic           prev_mul_rst = 1'b0;
  logic           prev_rsp_valid = 1'b0;
  int             grant_q[$];
  int             grant_cyc_q[$];
  int             valid_cyc_q[$];
  int             rspid_q[$];
  logic [2*W-1:0] rspd_q[$];

  always @(negedge clk) begin
    seen_ready = req_ready;
    if (!rst) begin
      check_output("rst_req_ready", 64'(req_ready), 64'(0));
      check_output("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      check_output("rst_rsp_id", 64'(rsp_id), 64'(0));
      check_output("rst_rsp_data", rsp_data, 64'(0));
      check_output("rst_busy", 64'(busy), 64'(0));
      check_output("rst_mul_rst", 64'(mul_rst), 64'(1));
      check_output("rst_mul_en", 64'(mul_en), 64'(0));
      check_output("rst_mul_load", 64'(mul_load), 64'(0));
      check_output("rst_mul_a", 64'(mul_a), 64'(0));
      check_output("rst_mul_b", 64'(mul_b), 64'(0));
      m_t   = -1;
      m_ptr = 0;
    end else begin
      g = -1;
      e_ready = '0;
      if (m_t < 0)
        for (int i = 0; i < N; i++)
          if (g < 0 && req_valid[(m_ptr + i) % N]) g = (m_ptr + i) % N;
      if (g >= 0) e_ready[g] = 1'b1;
      check_output("req_ready", 64'(req_ready), 64'(e_ready));
      check_output("busy", 64'(busy), 64'(m_t >= 1));
      check_output("mul_rst", 64'(mul_rst), 64'(m_t == 1));
      check_output("mul_load", 64'(mul_load), 64'(m_t == 2));
      check_output("mul_en", 64'(mul_en), 64'(m_t >= 2 && m_t <= 2 + LAT));
      check_output("rsp_valid", 64'(rsp_valid), 64'(m_t == 3 + LAT));
      if (m_t >= 2 && m_t <= 2 + LAT) begin
        check_output("mul_a", 64'(mul_a), 64'(m_a));
        check_output("mul_b", 64'(mul_b), 64'(m_b));
      end
      if (m_t == 3 + LAT) begin
        check_output("rsp_id", 64'(rsp_id), 64'(m_id));
        check_output("rsp_data", rsp_data, m_prod);
      end
      if (mul_load) check_output("pin_clr_before_load", 64'(prev_mul_rst), 64'(1));

      for (int i = 0; i < N; i++)
        if (req_ready[i]) begin
          grant_q.push_back(i);
          grant_cyc_q.push_back(cyc);
        end
      if (rsp_valid && !prev_rsp_valid) valid_cyc_q.push_back(cyc);
      if (rsp_valid && rsp_ready) begin
        rspid_q.push_back(int'(rsp_id));
        rspd_q.push_back(rsp_data);
      end

      if (m_t < 0) begin
        if (g >= 0) begin
          m_id   = g;
          m_a    = req_a[g*W +: W];
          m_b    = req_b[g*W +: W];
          m_prod = mulref(m_a, m_b);
          m_ptr  = (g + 1) % N;
          m_t    = 1;
        end
      end else if (m_t < 3 + LAT) m_t++;
      else if (rsp_ready) m_t = -1;
    end
    prev_mul_rst   = mul_rst;
    prev_rsp_valid = rsp_valid && rst;
  end

  // One cycle step: requesters drop their request once they have seen their grant.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (seen_ready[i]) valid_r[i] = 1'b0;
  endtask

  task automatic apply_stimulus(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    valid_r[i] = 1'b1;
    a_r[i]     = a;
    b_r[i]     = b;
  endtask

  task automatic clear_logs();
    grant_q.delete();
    grant_cyc_q.delete();
    valid_cyc_q.delete();
    rspid_q.delete();
    rspd_q.delete();
  endtask

  task automatic reset_dut();
    valid_r = '0;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    clear_logs();
  endtask

  task automatic wait_rsp(input string name, input int n, input int limit);
    int k;
    k = 0;
    while (rspd_q.size() < n && k < limit) begin
      tick();
      k++;
    end
    check_output(name, 64'(rspd_q.size()), 64'(n));
  endtask

  function automatic logic [W-1:0] randop();
    case ($urandom_range(0, 7))
      0:       return 32'h8000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return '0;
      3:       return '1;
      default: return $urandom;
    endcase
  endfunction

  int             n;
  int             gcyc;
  logic [2*W-1:0] exp4 [4];

  initial begin
    valid_r   = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      a_r[i] = '0;
      b_r[i] = '0;
    end
    #1 rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;

    // Single job with exact latency.
    reset_dut();
    apply_stimulus(0, 12, -32);
    wait_rsp("single_count", 1, 100);
    check_output("single_id", 64'(rspid_q[0]), 64'(0));
    check_output("single_data", rspd_q[0], 64'(-384));
    check_output("single_latency", 64'(valid_cyc_q[0] - grant_cyc_q[0]), 64'(3 + LAT));

    // All four at once, granted in index order.
    reset_dut();
    exp4 = '{64'(204), 64'(1500), 64'(0), 64'(260)};
    apply_stimulus(0, -51, -4);
    apply_stimulus(1, -25, -60);
    apply_stimulus(2, 0, 1234);
    apply_stimulus(3, 13, 20);
    wait_rsp("four_count", 4, 400);
    for (int i = 0; i < 4; i++) begin
      check_output("four_grant", 64'(grant_q[i]), 64'(i));
      check_output("four_id", 64'(rspid_q[i]), 64'(i));
      check_output("four_data", rspd_q[i], exp4[i]);
    end

    // Back-pressure: response held, no grants, busy stays high.
    reset_dut();
    rsp_ready = 1'b0;
    apply_stimulus(2, 7, -9);
    n = 0;
    while (!rsp_valid && n < 100) begin
      tick();
      n++;
    end
    check_output("bp_reach_done", 64'(rsp_valid), 64'(1));
    apply_stimulus(0, 5, 5);
    for (int c = 0; c < 10; c++) begin
      tick();
      check_output("bp_valid", 64'(rsp_valid), 64'(1));
      check_output("bp_data", rsp_data, 64'(-63));
      check_output("bp_id", 64'(rsp_id), 64'(2));
      check_output("bp_req_ready", 64'(req_ready), 64'(0));
      check_output("bp_busy", 64'(busy), 64'(1));
    end
    rsp_ready = 1'b1;
    wait_rsp("bp_count", 2, 200);
    check_output("bp_first_id", 64'(rspid_q[0]), 64'(2));
    check_output("bp_first_data", rspd_q[0], 64'(-63));
    check_output("bp_second_data", rspd_q[1], 64'(25));

    // Rotation: pointer lands on 2, so 3 wins over 1.
    reset_dut();
    apply_stimulus(1, 3, 4);
    wait_rsp("rot_first_count", 1, 100);
    apply_stimulus(1, 2, 2);
    apply_stimulus(3, -1, 5);
    wait_rsp("rot_count", 3, 200);
    check_output("rot_grant_a", 64'(grant_q[1]), 64'(3));
    check_output("rot_grant_b", 64'(grant_q[2]), 64'(1));
    check_output("rot_data_a", rspd_q[1], 64'(-5));
    check_output("rot_data_b", rspd_q[2], 64'(4));

    // Reset in the middle of RUN drops the job.
    reset_dut();
    apply_stimulus(0, 100, 3);
    n = 0;
    while (grant_cyc_q.size() == 0 && n < 20) begin
      tick();
      n++;
    end
    check_output("midrst_granted", 64'(grant_cyc_q.size()), 64'(1));
    gcyc = (grant_cyc_q.size() > 0) ? grant_cyc_q[0] : cyc;
    n = 0;
    while (cyc < gcyc + 8 && n < 20) begin
      tick();
      n++;
    end
    check_output("midrst_in_run", 64'(mul_en && !mul_load), 64'(1));
    rst = 1'b0;
    #1;
    check_output("midrst_busy", 64'(busy), 64'(0));
    check_output("midrst_mul_rst", 64'(mul_rst), 64'(1));
    tick();
    rst = 1'b1;
    repeat (60) tick();
    check_output("midrst_no_rsp", 64'(rspd_q.size()), 64'(0));
    apply_stimulus(1, 1, 12);
    wait_rsp("midrst_next_count", 1, 100);
    check_output("midrst_next_id", 64'(rspid_q[0]), 64'(1));
    check_output("midrst_next_data", rspd_q[0], 64'(12));

    // Randomized traffic with drops and random back-pressure.
    reset_dut();
    for (int c = 0; c < 2500; c++) begin
      tick();
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if (!valid_r[i]) begin
          if ($urandom_range(0, 15) == 0) apply_stimulus(i, randop(), randop());
        end else if ($urandom_range(0, 63) == 0) begin
          valid_r[i] = 1'b0;
        end
      end
    end
    rsp_ready = 1'b1;
    repeat (400) tick();
    check_output("rand_activity", 64'(rspd_q.size() >= 20), 64'(1));
    check_output("rand_drained", 64'(busy), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
